// File: rtl/apuf_pkg.sv
// rtl/apuf_pkg.sv - shared state encoding and default parameters for the APUF response collector
package apuf_pkg;

    localparam int NRESP_DEF    = 32;
    localparam int TRIG_CYC_DEF = 4;
    localparam int TIMEOUT_DEF  = 1023;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_TRIG_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_TRIG = ST_TRIG_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_DONE = ST_DONE_ENC
    } apuf_state_t;

endpackage

// File: rtl/apuf_eval_timer.sv
// rtl/apuf_eval_timer.sv - shared counter timing the trigger pulse width and the response timeout
module apuf_eval_timer
    import apuf_pkg::*;
#(
    parameter int TRIG_CYC = TRIG_CYC_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic mode,
    output logic trig_done,
    output logic timeout
);

    localparam int LIMIT = (TIMEOUT > TRIG_CYC) ? TIMEOUT : TRIG_CYC;
    localparam int CW    = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Saturates instead of wrapping so a stalled state can never re-fire its terminal count.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (count != CW'(LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign trig_done = !mode && (count == CW'(TRIG_CYC - 1));
    assign timeout   = mode && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apuf_resp_collector.sv
// rtl/apuf_resp_collector.sv - runs NRESP trigger/capture evaluations and presents the packed word
// Optional majority voting over three evaluations per bit: APUF_MAJORITY_VOTE_EN.
module apuf_resp_collector
    import apuf_pkg::*;
#(
    parameter int NRESP    = NRESP_DEF,
    parameter int TRIG_CYC = TRIG_CYC_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             tig_signal,
    input  logic             resp_ready,
    input  logic             resp_bit,
    output logic             busy,
    output logic             frame_valid,
    output logic [NRESP-1:0] resp_word,
    input  logic             resp_ack,
    output logic             timeout_err
);

    localparam int BW = $clog2(NRESP);

    apuf_state_t   state;
    apuf_state_t   state_next;
    logic [BW-1:0] bit_cnt;
    logic          trig_done;
    logic          timeout;
    logic          eval_done;
    logic          eval_bit;
    logic          last_eval;
    logic          stored_bit;

    apuf_eval_timer #(
        .TRIG_CYC (TRIG_CYC),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (state_next != state),
        .mode      (state == ST_WAIT),
        .trig_done (trig_done),
        .timeout   (timeout)
    );

    // A real response beats a timeout landing in the same cycle; a timed-out evaluation reads as 0.
    assign eval_done = (state == ST_WAIT) && (resp_ready || timeout);
    assign eval_bit  = resp_ready & resp_bit;

`ifdef APUF_MAJORITY_VOTE_EN
    logic [1:0] vote_cnt;
    logic [1:0] ones;
    logic [1:0] vote_sum;

    assign vote_sum   = ones + 2'(eval_bit);
    assign last_eval  = (vote_cnt == 2'd2);
    assign stored_bit = vote_sum[1];

    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE) begin
            vote_cnt <= '0;
            ones     <= '0;
        end else if (eval_done) begin
            vote_cnt <= last_eval ? 2'd0 : vote_cnt + 2'd1;
            ones     <= last_eval ? 2'd0 : vote_sum;
        end
    end
`else
    assign last_eval  = 1'b1;
    assign stored_bit = eval_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_TRIG;
            ST_TRIG: if (trig_done) state_next = ST_WAIT;
            ST_WAIT: begin
                if (eval_done) begin
                    if (last_eval && bit_cnt == BW'(NRESP - 1)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_TRIG;
                    end
                end
            end
            ST_DONE: if (resp_ack) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tig_signal  <= 1'b0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            resp_word   <= '0;
            timeout_err <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            tig_signal  <= (state_next == ST_TRIG);
            busy        <= (state_next != ST_IDLE);
            frame_valid <= (state_next == ST_DONE);
            if (state == ST_IDLE && start) begin
                resp_word   <= '0;
                timeout_err <= 1'b0;
                bit_cnt     <= '0;
            end else if (eval_done) begin
                if (timeout && !resp_ready) begin
                    timeout_err <= 1'b1;
                end
                if (last_eval) begin
                    resp_word[bit_cnt] <= stored_bit;
                    if (bit_cnt != BW'(NRESP - 1)) begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apuf_resp_collector.sv
// tb/tb_apuf_resp_collector.sv - randomized self-checking bench with a per-cycle phase/timeline model
module tb_apuf_resp_collector;

    localparam int NRESP    = 8;
    localparam int TRIG_CYC = 4;
    localparam int TIMEOUT  = 15;
`ifdef APUF_MAJORITY_VOTE_EN
    localparam int NV = 3;
`else
    localparam int NV = 1;
`endif
    localparam int NE = NRESP * NV;
    localparam int NO_RESP = 99;

    localparam int P_IDLE = 0;
    localparam int P_TRIG = 1;
    localparam int P_WAIT = 2;
    localparam int P_DONE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             resp_ready = 1'b0;
    logic             resp_bit = 1'b0;
    logic             resp_ack = 1'b0;
    logic             tig_signal;
    logic             busy;
    logic             frame_valid;
    logic             timeout_err;
    logic [NRESP-1:0] resp_word;

    apuf_resp_collector #(
        .NRESP    (NRESP),
        .TRIG_CYC (TRIG_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tig_signal  (tig_signal),
        .resp_ready  (resp_ready),
        .resp_bit    (resp_bit),
        .busy        (busy),
        .frame_valid (frame_valid),
        .resp_word   (resp_word),
        .resp_ack    (resp_ack),
        .timeout_err (timeout_err)
    );

    logic             chk_en = 1'b0;
    logic             e_tig = 1'b0;
    logic             e_busy = 1'b0;
    logic             e_fv = 1'b0;
    logic             e_err = 1'b0;
    logic [NRESP-1:0] e_word = '0;
    logic [NRESP-1:0] m_word = '0;
    logic             m_err = 1'b0;
    int               n_pass = 0;
    int               n_total = 0;
    int               tig_pulses = 0;
    logic             tig_prev = 1'b0;
    int               plan_d [NE];
    logic             plan_b [NE];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    function automatic logic coin(input int one_in);
        return ($urandom_range(0, one_in - 1) == 0);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("tig_signal", 32'(tig_signal), 32'(e_tig));
            check("busy", 32'(busy), 32'(e_busy));
            check("frame_valid", 32'(frame_valid), 32'(e_fv));
            check("resp_word", 32'(resp_word), 32'(e_word));
            check("timeout_err", 32'(timeout_err), 32'(e_err));
        end
        if (tig_signal === 1'b1 && tig_prev !== 1'b1) tig_pulses++;
        tig_prev = tig_signal;
    end

    // One clock cycle: inputs applied for the coming edge, expectations for the cycle just entered.
    task automatic step(input int ph, input logic st, input logic rr, input logic rb,
                        input logic ack, input logic rs);
        @(posedge clk);
        #1;
        start      = st;
        resp_ready = rr;
        resp_bit   = rb;
        resp_ack   = ack;
        rst        = rs;
        e_tig      = (ph == P_TRIG);
        e_busy     = (ph != P_IDLE);
        e_fv       = (ph == P_DONE);
        e_word     = m_word;
        e_err      = m_err;
        chk_en     = 1'b1;
    endtask

    task automatic set_plan(input logic [NRESP-1:0] bits, input int d);
        for (int e = 0; e < NE; e++) begin
            plan_d[e] = d;
            plan_b[e] = bits[e / NV];
        end
    endtask

    // plan_d: WAIT cycle index of the resp_ready pulse; >= TIMEOUT means the arbiter never answers.
    task automatic run_frame(input int abort_bit, input int hold, input logic ack_start,
                             input logic noise);
        int   p0;
        int   ones;
        int   d;
        int   wl;
        int   e;
        logic r;
        p0 = tig_pulses;
        step(P_IDLE, 1'b1, noise & coin(3), coin(2), noise & coin(3), 1'b0);
        m_word = '0;
        m_err  = 1'b0;
        for (int k = 0; k < NRESP; k++) begin
            ones = 0;
            for (int v = 0; v < NV; v++) begin
                e = k * NV + v;
                d = plan_d[e];
                for (int t = 0; t < TRIG_CYC; t++)
                    step(P_TRIG, noise & coin(3), noise & coin(3), coin(2), noise & coin(3), 1'b0);
                if (k == abort_bit && v == 0) begin
                    step(P_WAIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                    m_word = '0;
                    m_err  = 1'b0;
                    step(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    return;
                end
                wl = (d < TIMEOUT) ? d + 1 : TIMEOUT;
                for (int i = 0; i < wl; i++)
                    step(P_WAIT, noise & coin(3), (i == d), (i == d) ? plan_b[e] : coin(2),
                         noise & coin(3), 1'b0);
                r = (d < TIMEOUT) ? plan_b[e] : 1'b0;
                if (d >= TIMEOUT) m_err = 1'b1;
                ones += int'(r);
            end
            m_word[k] = (2 * ones > NV);
        end
        for (int h = 0; h < hold; h++)
            step(P_DONE, noise & coin(2), noise & coin(3), coin(2), 1'b0, 1'b0);
        step(P_DONE, ack_start, 1'b0, 1'b0, 1'b1, 1'b0);
        step(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tig_pulses", 32'(tig_pulses - p0), 32'(NE));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NRESP-1:0] w;
        repeat (3) step(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(P_IDLE, 1'b0, coin(2), coin(2), coin(2), 1'b0);

        // Basic frame, response 3 cycles after each trigger fall.
        set_plan(8'h4D, 3);
        run_frame(-1, 2, 1'b0, 1'b0);
        check("t1_word", 32'(resp_word), 32'h4D);
        check("t1_model", 32'(m_word), 32'h4D);
        check("t1_err", 32'(timeout_err), 32'h0);

        // Bit 2 never answers.
        set_plan(8'hFF, 3);
        for (int v = 0; v < NV; v++) plan_d[2 * NV + v] = NO_RESP;
        run_frame(-1, 1, 1'b0, 1'b0);
        check("t2_word", 32'(resp_word), 32'hFB);
        check("t2_err", 32'(timeout_err), 32'h1);

        // Stray starts everywhere, long DONE hold, ack together with start.
        set_plan(8'h3C, 2);
        run_frame(-1, 6, 1'b1, 1'b1);
        repeat (3) step(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_word", 32'(resp_word), 32'h3C);

        // Reset while waiting on bit 5, then a clean frame.
        set_plan(8'hA5, 4);
        run_frame(5, 0, 1'b0, 1'b1);
        check("t4_word", 32'(resp_word), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        set_plan(8'h4D, 3);
        run_frame(-1, 0, 1'b0, 1'b0);
        check("t4_clean", 32'(resp_word), 32'h4D);

        // Response lands on the timeout cycle of bit 3.
        set_plan(8'hBF, 1);
        for (int v = 0; v < NV; v++) plan_d[3 * NV + v] = TIMEOUT - 1;
        repeat (2) step(P_IDLE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(-1, 1, 1'b0, 1'b1);
        check("t5_word", 32'(resp_word), 32'hBF);
        check("t5_err", 32'(timeout_err), 32'h0);

`ifdef APUF_MAJORITY_VOTE_EN
        set_plan(8'hF0, 2);
        plan_b[0] = 1'b1; plan_b[1] = 1'b0; plan_b[2] = 1'b1;
        plan_b[3] = 1'b0; plan_b[4] = 1'b0; plan_b[5] = 1'b1;
        plan_b[6] = 1'b1; plan_b[7] = 1'b1; plan_b[8] = 1'b1;
        run_frame(-1, 1, 1'b0, 1'b0);
        w = resp_word;
        check("t6_votes", 32'(w[2:0]), 32'h5);
        check("t6_word", 32'(w), 32'hF5);
`endif

        for (int f = 0; f < 10; f++) begin
            for (int e = 0; e < NE; e++) begin
                plan_d[e] = coin(6) ? NO_RESP : int'($urandom_range(0, TIMEOUT - 1));
                plan_b[e] = coin(2);
            end
            run_frame((f == 4) ? int'($urandom_range(0, NRESP - 1)) : -1,
                      int'($urandom_range(0, 3)), coin(2), 1'b1);
            repeat ($urandom_range(1, 3)) step(P_IDLE, 1'b0, coin(3), coin(2), coin(3), 1'b0);
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
